// File: rtl/grid_scan_driver.sv
// Row-multiplexed 8x8 LED driver for the life-grid word; snapshots a grid via valid/ready at frame boundaries.
// Optional macro GRID_SCAN_BLANK_EN inserts one blank cycle after every row for ghost suppression.
module grid_scan_driver #(
  parameter int DWELL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] grid,
  input  logic        grid_valid,
  output logic        grid_ready,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_done,
  output logic        busy
);

  // state | meaning
  // IDLE  | outputs dark, grid always accepted, waits for enable and a snapshot
  // SCAN  | drives one row of the snapshot for DWELL_CYCLES cycles
  // BLANK | one dark cycle between rows (GRID_SCAN_BLANK_EN only)
`ifdef GRID_SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN} state_t;
`endif

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  state_t        state, state_n;
  logic [63:0]   snapshot, snap_n;
  logic          have_snap, have_snap_n;
  logic [2:0]    row, row_n;
  logic [DW-1:0] dwell, dwell_n;
  logic          last_dwell, is_e, eof_n;

  always_comb begin
    last_dwell  = (dwell == DWELL_LAST);
`ifdef GRID_SCAN_BLANK_EN
    is_e        = (state == BLANK) && (row == 3'd7);
`else
    is_e        = (state == SCAN) && (row == 3'd7) && last_dwell;
`endif
    grid_ready  = (state == IDLE) || is_e;
    state_n     = state;
    row_n       = row;
    dwell_n     = dwell;
    snap_n      = snapshot;
    have_snap_n = have_snap;

    if (grid_ready && grid_valid) begin
      snap_n      = grid;
      have_snap_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (enable && (have_snap || grid_valid)) begin
          state_n = SCAN;
          row_n   = 3'd0;
          dwell_n = '0;
        end
      end
      SCAN: begin
        if (!last_dwell) begin
          dwell_n = dwell + 1'b1;
        end else begin
          dwell_n = '0;
`ifdef GRID_SCAN_BLANK_EN
          state_n = BLANK;
`else
          // row 7 wraps to 0 naturally; enable is only honoured at the frame end
          row_n = row + 3'd1;
          if (is_e && !enable) state_n = IDLE;
`endif
        end
      end
`ifdef GRID_SCAN_BLANK_EN
      BLANK: begin
        row_n   = row + 3'd1;
        dwell_n = '0;
        state_n = (is_e && !enable) ? IDLE : SCAN;
      end
`endif
      default: state_n = IDLE;
    endcase

`ifdef GRID_SCAN_BLANK_EN
    eof_n = (state_n == BLANK) && (row_n == 3'd7);
`else
    eof_n = (state_n == SCAN) && (row_n == 3'd7) && (dwell_n == DWELL_LAST);
`endif
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      snapshot   <= '0;
      have_snap  <= 1'b0;
      row        <= 3'd0;
      dwell      <= '0;
      row_sel    <= 8'd0;
      col_data   <= 8'd0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      snapshot   <= snap_n;
      have_snap  <= have_snap_n;
      row        <= row_n;
      dwell      <= dwell_n;
      row_sel    <= (state_n == SCAN) ? (8'd1 << row_n) : 8'd0;
      col_data   <= (state_n == SCAN) ? snap_n[{row_n, 3'b000} +: 8] : 8'd0;
      frame_done <= eof_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_grid_scan_driver.sv
// Directed bench for grid_scan_driver: DWELL=4 instance for most scenarios, DWELL=1 instance for the minimum-dwell case.
module tb_grid_scan_driver;

`ifdef GRID_SCAN_BLANK_EN
  localparam int BLK = 1;
`else
  localparam int BLK = 0;
`endif
  localparam int F4 = 8 * (4 + BLK);
  localparam int F1 = 8 * (1 + BLK);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, enable1 = 1'b0;
  logic [63:0] grid = '0, grid1 = '0;
  logic        grid_valid = 1'b0, grid_valid1 = 1'b0;
  logic        grid_ready, grid_ready1;
  logic [7:0]  row_sel, col_data, row_sel1, col_data1;
  logic        frame_done, busy, frame_done1, busy1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  grid_scan_driver #(.DWELL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .grid(grid), .grid_valid(grid_valid),
    .grid_ready(grid_ready), .row_sel(row_sel), .col_data(col_data),
    .frame_done(frame_done), .busy(busy));

  grid_scan_driver #(.DWELL_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable1), .grid(grid1), .grid_valid(grid_valid1),
    .grid_ready(grid_ready1), .row_sel(row_sel1), .col_data(col_data1),
    .frame_done(frame_done1), .busy(busy1));

  // expected row drive for frame cycle k
  function automatic logic [7:0] e_sel(int k, int dw);
    int p = dw + BLK;
    if ((k % p) >= dw) return 8'd0;
    return 8'd1 << (k / p);
  endfunction

  function automatic logic [7:0] e_col(logic [63:0] g, int k, int dw);
    int p = dw + BLK;
    if ((k % p) >= dw) return 8'd0;
    return g[(k / p) * 8 +: 8];
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if (row_sel !== 8'd0 || col_data !== 8'd0) begin fails++;
      $display("FAIL reset_rows: row_sel=%h col_data=%h want 00 00", row_sel, col_data); end
    tests++; if (frame_done !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL reset_flags: frame_done=%b busy=%b want 0 0", frame_done, busy); end
    tests++; if (grid_ready !== 1'b1) begin fails++;
      $display("FAIL reset_ready: grid_ready=%b want 1", grid_ready); end
    reset = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0 || row_sel !== 8'd0 || grid_ready !== 1'b1) begin fails++;
      $display("FAIL idle_nosnap: busy=%b row_sel=%h ready=%b want 0 00 1", busy, row_sel, grid_ready); end
  endtask

  task automatic test_basic(input logic [63:0] g);
    grid = g; grid_valid = 1'b1;
    for (int k = 0; k < F4; k++) begin
      @(negedge clk);
      if (k == 0) grid_valid = 1'b0;
      tests++; if (row_sel !== e_sel(k, 4) || col_data !== e_col(g, k, 4)) begin fails++;
        $display("FAIL basic_row k=%0d: row_sel=%h col_data=%h want %h %h", k, row_sel, col_data, e_sel(k, 4), e_col(g, k, 4)); end
      tests++; if (frame_done !== (k == F4 - 1) || grid_ready !== (k == F4 - 1) || busy !== 1'b1) begin fails++;
        $display("FAIL basic_flags k=%0d: frame_done=%b ready=%b busy=%b", k, frame_done, grid_ready, busy); end
    end
    @(negedge clk);
    tests++; if (row_sel !== 8'h01 || col_data !== 8'h28 || frame_done !== 1'b0) begin fails++;
      $display("FAIL basic_wrap: row_sel=%h col_data=%h fd=%b want 01 28 0", row_sel, col_data, frame_done); end
  endtask

  // entered with frame cycle 0 of the old grid already checked
  task automatic test_midframe(input logic [63:0] oldg, input logic [63:0] newg);
    for (int k = 1; k < F4; k++) begin
      @(negedge clk);
      tests++; if (row_sel !== e_sel(k, 4) || col_data !== e_col(oldg, k, 4)) begin fails++;
        $display("FAIL mid_old k=%0d: row_sel=%h col_data=%h want %h %h", k, row_sel, col_data, e_sel(k, 4), e_col(oldg, k, 4)); end
      tests++; if (grid_ready !== (k == F4 - 1)) begin fails++;
        $display("FAIL mid_ready k=%0d: grid_ready=%b want %b", k, grid_ready, (k == F4 - 1)); end
      if (k == 3 * (4 + BLK)) begin grid = newg; grid_valid = 1'b1; end
    end
    for (int k = 0; k < F4; k++) begin
      @(negedge clk);
      if (k == 0) grid_valid = 1'b0;
      tests++; if (row_sel !== e_sel(k, 4) || col_data !== e_col(newg, k, 4)) begin fails++;
        $display("FAIL mid_new k=%0d: row_sel=%h col_data=%h want %h %h", k, row_sel, col_data, e_sel(k, 4), e_col(newg, k, 4)); end
    end
  endtask

  task automatic test_enable_drop(input logic [63:0] g);
    for (int k = 0; k < F4; k++) begin
      @(negedge clk);
      tests++; if (row_sel !== e_sel(k, 4) || col_data !== e_col(g, k, 4) || busy !== 1'b1) begin fails++;
        $display("FAIL drop_frame k=%0d: row_sel=%h col_data=%h busy=%b want %h %h 1", k, row_sel, col_data, busy, e_sel(k, 4), e_col(g, k, 4)); end
      if (k == 2 * (4 + BLK)) enable = 1'b0;
    end
    @(negedge clk);
    tests++; if (row_sel !== 8'd0 || col_data !== 8'd0 || busy !== 1'b0 || grid_ready !== 1'b1 || frame_done !== 1'b0) begin fails++;
      $display("FAIL drop_idle: row_sel=%h col=%h busy=%b ready=%b fd=%b want 00 00 0 1 0", row_sel, col_data, busy, grid_ready, frame_done); end
    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < F4; k++) begin
      @(negedge clk);
      tests++; if (row_sel !== e_sel(k, 4) || col_data !== e_col(g, k, 4)) begin fails++;
        $display("FAIL drop_restart k=%0d: row_sel=%h col_data=%h want %h %h", k, row_sel, col_data, e_sel(k, 4), e_col(g, k, 4)); end
    end
  endtask

  // entered with the next frame about to start at cycle 0
  task automatic test_reset_mid();
    for (int k = 0; k <= 5 * (4 + BLK) + 1; k++) @(negedge clk);
    tests++; if (row_sel !== 8'h20) begin fails++;
      $display("FAIL rst_pre: row_sel=%h want 20", row_sel); end
    #2 reset = 1'b1;
    #1;
    tests++; if (row_sel !== 8'd0 || col_data !== 8'd0 || busy !== 1'b0) begin fails++;
      $display("FAIL rst_async: row_sel=%h col_data=%h busy=%b want 00 00 0", row_sel, col_data, busy); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      tests++; if (row_sel !== 8'd0 || busy !== 1'b0 || grid_ready !== 1'b1) begin fails++;
        $display("FAIL rst_noscan: row_sel=%h busy=%b ready=%b want 00 0 1", row_sel, busy, grid_ready); end
    end
  endtask

  task automatic test_min_dwell(input logic [63:0] g);
    grid1 = g; grid_valid1 = 1'b1; enable1 = 1'b1;
    for (int k = 0; k < 2 * F1; k++) begin
      @(negedge clk);
      if (k == 0) grid_valid1 = 1'b0;
      tests++; if (row_sel1 !== col_data1 || row_sel1 !== e_sel(k % F1, 1)) begin fails++;
        $display("FAIL min_diag k=%0d: row_sel=%h col_data=%h want %h", k, row_sel1, col_data1, e_sel(k % F1, 1)); end
      tests++; if (frame_done1 !== ((k % F1) == F1 - 1) || grid_ready1 !== ((k % F1) == F1 - 1)) begin fails++;
        $display("FAIL min_fd k=%0d: frame_done=%b ready=%b want %b", k, frame_done1, grid_ready1, ((k % F1) == F1 - 1)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic(64'h0412_6424_0034_3C28);
    test_midframe(64'h0412_6424_0034_3C28, 64'hFFFF_0000_0000_0000);
    test_enable_drop(64'hFFFF_0000_0000_0000);
    test_reset_mid();
    test_min_dwell(64'h8040_2010_0804_0201);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
